// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the main-memory responder.
//   state_t        : responder state machine encoding (IDLE, WAIT, XFER, COMMIT)
//   DEFAULT_*      : default geometry and access latency
//   BLOCK_BYTES    : bytes per refill block at the default geometry
//   unpack_word()  : 32-bit word -> four bytes, little-endian (byte 0 = bits 7:0)
//   pack_word()    : four bytes -> 32-bit word, little-endian
// -----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        XFER,
        COMMIT
    } state_t;

    localparam int DEFAULT_ADDR_W      = 10;
    localparam int DEFAULT_BLOCK_WORDS = 4;
    localparam int DEFAULT_LATENCY     = 4;
    localparam int BLOCK_BYTES         = 4 * DEFAULT_BLOCK_WORDS;

    // Element k of the packed array is byte k of the word (bits 8k+7:8k).
    typedef logic [3:0][7:0] word_bytes_t;

    function automatic word_bytes_t unpack_word(input logic [31:0] word);
        return word_bytes_t'(word);
    endfunction

    function automatic logic [31:0] pack_word(input word_bytes_t bytes);
        return {bytes[3], bytes[2], bytes[1], bytes[0]};
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// -----------------------------------------------------------------------------
// mem_byte_array
// Byte-addressed storage, 2^ADDR_W bytes, held in Memory[] so the contents can
// be inspected byte by byte. Cleared to 0x00 by a synchronous reset.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   wr_en      : write the four bytes of wr_data starting at wr_addr
//   wr_addr    : byte address of the write (wraps modulo 2^ADDR_W)
//   wr_data    : write word, stored little-endian
//   rd_addr    : byte address of the combinational read (wraps)
//   rd_data    : word {M[a+3], M[a+2], M[a+1], M[a]}
// -----------------------------------------------------------------------------
module mem_byte_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0]  Memory [0:DEPTH-1];
    word_bytes_t wr_bytes;
    word_bytes_t rd_bytes;

    assign wr_bytes = unpack_word(wr_data);

    // NOTE: clearing every entry on reset turns the array into flops rather than
    // a RAM macro; the all-zero power-up image is a functional requirement here.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                Memory[i] <= 8'h00;
            end
        end else if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                Memory[wr_addr + ADDR_W'(k)] <= wr_bytes[k];
            end
        end
    end

    // NOTE: the default assignment up front keeps this block free of latches
    // even if the loop below is later edited to cover fewer bytes.
    always_comb begin
        rd_bytes = '0;
        for (int k = 0; k < 4; k++) begin
            rd_bytes[k] = Memory[rd_addr + ADDR_W'(k)];
        end
    end

    assign rd_data = pack_word(rd_bytes);

endmodule

// File: rtl/main_memory_responder.sv
// -----------------------------------------------------------------------------
// main_memory_responder
// Far end of the cache-to-memory interface. Accepts one request at a time on a
// valid/ready channel: block reads stream BLOCK_WORDS beats, word writes return
// a single echo beat. The first beat appears LATENCY cycles after acceptance.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   req_valid    : request present            req_ready : responder is IDLE
//   req_write    : 1 = word write, 0 = read   req_addr  : byte address
//   req_wdata    : write word
//   resp_valid   : response beat (no backpressure)
//   resp_data    : read word or write echo    resp_last : final beat
//   resp_beat    : word index within the block
// Build option:
//   MEM_WRITE_BUFFER_EN : posted write; the ack beat follows acceptance by one
//                         cycle and the bytes commit LATENCY cycles after
//                         acceptance, with req_ready held low until then.
// -----------------------------------------------------------------------------
module main_memory_responder
    import mem_pkg::*;
#(
    parameter int   ADDR_W      = DEFAULT_ADDR_W,
    parameter int   BLOCK_WORDS = DEFAULT_BLOCK_WORDS,
    parameter int   LATENCY     = DEFAULT_LATENCY,
    localparam int  BEAT_W      = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              resp_last,
    output logic [BEAT_W-1:0] resp_beat
);

    localparam int                LAT_W       = $clog2(LATENCY) + 1;
    localparam int                BLOCK_OFF_W = $clog2(BLOCK_WORDS) + 2;
    localparam logic [ADDR_W-1:0] BLOCK_MASK  = ~ADDR_W'((1 << BLOCK_OFF_W) - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK   = ~ADDR_W'(3);
    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BLOCK_WORDS - 1);

    state_t            state;
    logic [LAT_W-1:0]  lat_cnt;
    logic              cap_write;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wdata;
    logic [BEAT_W-1:0] beat_cnt;   // index of the next read beat to emit

    logic              wait_done;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;

    assign req_ready = (state == IDLE);
    assign wait_done = (state == WAIT) && (lat_cnt == LAT_W'(LATENCY - 1));
    // The write lands on the edge that leaves WAIT, in both build variants.
    assign mem_wr_en = wait_done && cap_write;
    // cap_addr is block aligned for reads, so OR-ing in the word offset is an add.
    assign rd_addr   = cap_addr | (ADDR_W'(beat_cnt) << 2);

    mem_byte_array #(
        .ADDR_W (ADDR_W)
    ) mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (mem_wr_en),
        .wr_addr (cap_addr),
        .wr_data (cap_wdata),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // NOTE: every register here uses <= so that all of them see the values from
    // before the edge; a blocking = would let later lines read updated state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            cap_write  <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            beat_cnt   <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_last  <= 1'b0;
            resp_beat  <= '0;
        end else begin
            // Beats last one cycle unless re-asserted below; data and index hold.
            resp_valid <= 1'b0;
            resp_last  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= WAIT;
                        lat_cnt   <= '0;
                        beat_cnt  <= '0;
                        cap_write <= req_write;
                        cap_addr  <= req_addr & (req_write ? WORD_MASK : BLOCK_MASK);
                        cap_wdata <= req_wdata;
`ifdef MEM_WRITE_BUFFER_EN
                        if (req_write) begin
                            resp_valid <= 1'b1;
                            resp_data  <= req_wdata;
                            resp_last  <= 1'b1;
                            resp_beat  <= '0;
                        end
`endif
                    end
                end
                WAIT: begin
                    if (!wait_done) begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end else if (cap_write) begin
`ifdef MEM_WRITE_BUFFER_EN
                        // Already acknowledged; the commit edge frees the port.
                        state      <= IDLE;
`else
                        state      <= COMMIT;
                        resp_valid <= 1'b1;
                        resp_data  <= cap_wdata;
                        resp_last  <= 1'b1;
                        resp_beat  <= '0;
`endif
                    end else begin
                        state      <= XFER;
                        resp_valid <= 1'b1;
                        resp_data  <= rd_data;
                        resp_beat  <= beat_cnt;
                        resp_last  <= (beat_cnt == LAST_BEAT);
                        beat_cnt   <= beat_cnt + BEAT_W'(1);
                    end
                end
                XFER: begin
                    if (resp_last) begin
                        state <= IDLE;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_data  <= rd_data;
                        resp_beat  <= beat_cnt;
                        resp_last  <= (beat_cnt == LAST_BEAT);
                        beat_cnt   <= beat_cnt + BEAT_W'(1);
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
